// File: rtl/pixel_map_pkg.sv
// Shared types and constants for the raster coordinate mapper.
// Exports: frame state enum, screen defaults/centres, lane-bus width helper.
package pixel_map_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int DEF_BASE_STEP = 4915;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_CENTRE_X  = DEF_SCREEN_W / 2;
  localparam int DEF_CENTRE_Y  = DEF_SCREEN_H / 2;

  function automatic int centre_of(int n);
    return n / 2;
  endfunction

  function automatic int lane_bus_w(int lanes, int w);
    return lanes * w;
  endfunction

endpackage

// File: rtl/pixel_raster_mapper_if.sv
// View-config inputs and coordinate beat stream of the raster mapper.
// master: mapper side (drives beats/status); slave: control + sink side.
interface pixel_raster_mapper_if #(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int NUM_LANES         = 1
);
  import pixel_map_pkg::*;

  localparam int RW = lane_bus_w(NUM_LANES, ENGINE_DATA_WIDTH);

  logic                         start;
  logic [2:0]                   zoom;
  logic [ENGINE_DATA_WIDTH-1:0] x_offset;
  logic [ENGINE_DATA_WIDTH-1:0] y_offset;
  logic                         out_valid;
  logic                         out_ready;
  logic [RW-1:0]                real_x;
  logic [ENGINE_DATA_WIDTH-1:0] imag_y;
  logic [PIXEL_DATA_WIDTH-1:0]  pixel_x_out;
  logic [PIXEL_DATA_WIDTH-1:0]  pixel_y_out;
  logic                         out_last;
  logic                         busy;
  logic                         frame_done;

  modport master (
    input  start, zoom, x_offset, y_offset, out_ready,
    output out_valid, real_x, imag_y, pixel_x_out,
    output pixel_y_out, out_last, busy, frame_done
  );

  modport slave (
    output start, zoom, x_offset, y_offset, out_ready,
    input  out_valid, real_x, imag_y, pixel_x_out,
    input  pixel_y_out, out_last, busy, frame_done
  );

endinterface

// File: rtl/pixel_lane_calc.sv
// One coordinate lane: registered d*step, then registered +offset (wraps).
// Ports: clk, reset, en_i (pipeline advance), d_i, step_i, offset_i, res_o.
module pixel_lane_calc #(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en_i,
  input  logic signed [PIXEL_DATA_WIDTH:0] d_i,
  input  logic [ENGINE_DATA_WIDTH-1:0]     step_i,
  input  logic [ENGINE_DATA_WIDTH-1:0]     offset_i,
  output logic [ENGINE_DATA_WIDTH-1:0]     res_o
);
  localparam int EDW = ENGINE_DATA_WIDTH;

  logic [EDW-1:0] d_ext;
  logic [EDW-1:0] prod_d, prod_q;
  logic [EDW-1:0] res_d, res_q;

  // Only the low EDW bits of the full signed product are kept, and
  // those depend only on the low EDW bits of each operand.
  assign d_ext  = EDW'(d_i);
  assign prod_d = d_ext * step_i;
  assign res_d  = prod_q + offset_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_q <= '0;
      res_q  <= '0;
    end else if (en_i) begin
      prod_q <= prod_d;
      res_q  <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/pixel_raster_mapper.sv
// Raster-scan coordinate generator: frame FSM, counters, 3-stage pipeline.
// Ports: clk, reset (sync, active-low), bus (config in, beat stream out).
module pixel_raster_mapper
  import pixel_map_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH   = 10,
  parameter int ENGINE_DATA_WIDTH  = 25,
  parameter int ENGINE_FRACT_WIDTH = 20,
  parameter int SCREEN_WIDTH       = DEF_SCREEN_W,
  parameter int SCREEN_HEIGHT      = DEF_SCREEN_H,
  parameter int NUM_LANES          = 1,
  parameter int BASE_STEP          = DEF_BASE_STEP
) (
  input logic                   clk,
  input logic                   reset,
  pixel_raster_mapper_if.master bus
);
  localparam int PDW = PIXEL_DATA_WIDTH;
  localparam int EDW = ENGINE_DATA_WIDTH;
  localparam int RW  = lane_bus_w(NUM_LANES, EDW);
  localparam int CX  = centre_of(SCREEN_WIDTH);
  localparam int CY  = centre_of(SCREEN_HEIGHT);
  localparam logic [PDW-1:0] X_LAST = PDW'(SCREEN_WIDTH - NUM_LANES);
  localparam logic [PDW-1:0] Y_LAST = PDW'(SCREEN_HEIGHT - 1);
  localparam logic [PDW-1:0] X_INC  = PDW'(NUM_LANES);

  if (SCREEN_WIDTH % NUM_LANES != 0) begin : g_chk_w
    $error("SCREEN_WIDTH must be a multiple of NUM_LANES");
  end
  if (ENGINE_FRACT_WIDTH >= ENGINE_DATA_WIDTH) begin : g_chk_f
    $error("ENGINE_FRACT_WIDTH must be below ENGINE_DATA_WIDTH");
  end

  state_e         state_q, state_d;
  logic [PDW-1:0] x_cnt_q, x_cnt_d;
  logic [PDW-1:0] y_cnt_q, y_cnt_d;
  logic [2:0]     zoom_q, zoom_d;
  logic [EDW-1:0] x_off_q, x_off_d;
  logic [EDW-1:0] y_off_q, y_off_d;
  logic           done_q, done_d;

  logic           adv, issue, at_end, last_hs;
  logic           s0_vld_q, s0_last_q;
  logic [PDW-1:0] s0_x_q, s0_y_q;
  logic           s1_vld_q, s1_last_q;
  logic [PDW-1:0] s1_x_q, s1_y_q;
  logic           out_vld_q, out_last_q;
  logic [PDW-1:0] out_x_q, out_y_q;
  logic [EDW-1:0] step;
  logic [RW-1:0]  real_x;
  logic [EDW-1:0] imag_y;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign adv     = bus.out_ready | ~out_vld_q;
  assign at_end  = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);
  assign last_hs = out_vld_q & bus.out_ready & out_last_q;
  assign step    = EDW'(BASE_STEP) >> zoom_q;

  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    zoom_d  = zoom_q;
    x_off_d = x_off_q;
    y_off_d = y_off_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          x_cnt_d = '0;
          y_cnt_d = '0;
          zoom_d  = bus.zoom;
          x_off_d = bus.x_offset;
          y_off_d = bus.y_offset;
        end
      end
      RUN: begin
        if (adv) begin
          issue = 1'b1;
          if (at_end) begin
            state_d = DRAIN;
          end else if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + 1'b1;
          end else begin
            x_cnt_d = x_cnt_q + X_INC;
          end
        end
      end
      DRAIN: begin
        // Stay busy through the frame_done cycle so a start there is ignored.
        done_d = last_hs;
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      zoom_q     <= '0;
      x_off_q    <= '0;
      y_off_q    <= '0;
      done_q     <= 1'b0;
      s0_vld_q   <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_x_q     <= '0;
      s0_y_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_x_q    <= '0;
      out_y_q    <= '0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      zoom_q  <= zoom_d;
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
      done_q  <= done_d;
      if (adv) begin
        s0_vld_q   <= issue;
        s0_last_q  <= at_end;
        s0_x_q     <= x_cnt_q;
        s0_y_q     <= y_cnt_q;
        s1_vld_q   <= s0_vld_q;
        s1_last_q  <= s0_last_q;
        s1_x_q     <= s0_x_q;
        s1_y_q     <= s0_y_q;
        out_vld_q  <= s1_vld_q;
        out_last_q <= s1_last_q;
        out_x_q    <= s1_x_q;
        out_y_q    <= s1_y_q;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [PDW:0] dx;
    assign dx = $signed({1'b0, s0_x_q})
              + $signed((PDW+1)'(k))
              - $signed((PDW+1)'(CX));
    pixel_lane_calc #(
      .PIXEL_DATA_WIDTH (PDW),
      .ENGINE_DATA_WIDTH(EDW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en_i    (adv),
      .d_i     (dx),
      .step_i  (step),
      .offset_i(x_off_q),
      .res_o   (real_x[k*EDW +: EDW])
    );
  end

  logic signed [PDW:0] dy;
  assign dy = $signed({1'b0, s0_y_q}) - $signed((PDW+1)'(CY));

  pixel_lane_calc #(
    .PIXEL_DATA_WIDTH (PDW),
    .ENGINE_DATA_WIDTH(EDW)
  ) u_imag (
    .clk     (clk),
    .reset   (reset),
    .en_i    (adv),
    .d_i     (dy),
    .step_i  (step),
    .offset_i(y_off_q),
    .res_o   (imag_y)
  );

  assign bus.out_valid   = out_vld_q;
  assign bus.out_last    = out_last_q;
  assign bus.pixel_x_out = out_x_q;
  assign bus.pixel_y_out = out_y_q;
  assign bus.real_x      = real_x;
  assign bus.imag_y      = imag_y;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_pixel_raster_mapper.sv
// Scoreboard bench for pixel_raster_mapper on a reduced 32x6 screen.
// Frames are predicted from raster arithmetic; a monitor pops and compares.
module tb_pixel_raster_mapper;
  localparam int PDW  = 10;
  localparam int EDW  = 25;
  localparam int L    = 4;
  localparam int W    = 32;
  localparam int H    = 6;
  localparam int BASE = 4915;

  typedef struct packed {
    logic [PDW-1:0]   px;
    logic [PDW-1:0]   py;
    logic [L*EDW-1:0] re;
    logic [EDW-1:0]   im;
    logic             last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    compared = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    jitter = 1'b0;
  int    rdy_mode = 0;
  beat_t exp_q[$];

  pixel_raster_mapper_if #(
    .PIXEL_DATA_WIDTH (PDW),
    .ENGINE_DATA_WIDTH(EDW),
    .NUM_LANES        (L)
  ) bus ();

  pixel_raster_mapper #(
    .PIXEL_DATA_WIDTH  (PDW),
    .ENGINE_DATA_WIDTH (EDW),
    .ENGINE_FRACT_WIDTH(20),
    .SCREEN_WIDTH      (W),
    .SCREEN_HEIGHT     (H),
    .NUM_LANES         (L),
    .BASE_STEP         (BASE)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [EDW-1:0] wrap(input longint v);
    logic [63:0] t;
    t = v;
    return t[EDW-1:0];
  endfunction

  // Whole frame in raster order: coordinate = (pixel - centre)*step + offset.
  function automatic void push_frame(input logic [2:0] z,
                                     input logic [EDW-1:0] xo,
                                     input logic [EDW-1:0] yo);
    longint st, xe, ye;
    st = longint'(BASE >> z);
    xe = longint'($signed(xo));
    ye = longint'($signed(yo));
    for (int y = 0; y < H; y++) begin
      for (int bx = 0; bx < W / L; bx++) begin
        beat_t b;
        b.px = PDW'(bx * L);
        b.py = PDW'(y);
        for (int k = 0; k < L; k++)
          b.re[k*EDW +: EDW] = wrap(longint'(bx * L + k - W / 2) * st + xe);
        b.im = wrap(longint'(y - H / 2) * st + ye);
        b.last = (y == H - 1) && (bx == W / L - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 0) bus.out_ready = 1'b1;
    else if (rdy_mode == 2) bus.out_ready = 1'b0;
    else bus.out_ready = 1'($urandom_range(0, 1));
    if (jitter) begin
      bus.zoom     = 3'($urandom);
      bus.x_offset = EDW'($urandom);
      bus.y_offset = EDW'($urandom);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.frame_done && n < budget) begin
      tick();
      n++;
    end
    if (!bus.frame_done) begin
      compared++;
      errors++;
      $display("FAIL frame_done_timeout: no pulse in %0d cycles, required one", budget);
    end
  endtask

  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  bit    prev_last_hs = 1'b0;

  always @(negedge clk) begin
    beat_t act, e;
    if (!mon_en) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      act = '{px: bus.pixel_x_out, py: bus.pixel_y_out, re: bus.real_x,
              im: bus.imag_y, last: bus.out_last};
      if (prev_stall) begin
        compared++;
        if (!bus.out_valid || act != prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h",
                   bus.out_valid, act, prev_beat);
        end
      end
      if (bus.frame_done || prev_last_hs) begin
        compared++;
        if (bus.frame_done != prev_last_hs || bus.out_valid) begin
          errors++;
          $display("FAIL frame_done: got done=%0b v=%0b required done=%0b v=0",
                   bus.frame_done, bus.out_valid, prev_last_hs);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h required none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat: got %h required %h", act, e);
          end
        end
      end
      prev_stall   = bus.out_valid && !bus.out_ready;
      prev_beat    = act;
      prev_last_hs = bus.out_valid && bus.out_ready && bus.out_last;
    end
  end

  initial begin
    int n;
    logic [2:0] z;
    logic [EDW-1:0] xo, yo;
    bus.start = 1'b0;
    bus.zoom = '0;
    bus.x_offset = '0;
    bus.y_offset = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_real_zero", longint'(bus.real_x == '0), 1);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // zoom 0, zero offsets, latency and known corner values
    bus.start = 1'b1;
    push_frame(3'd0, '0, '0);
    tick();
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    check("first_latency", n, 3);
    check("first_re0", longint'($signed(bus.real_x[0 +: EDW])), -78640);
    check("first_re3", longint'($signed(bus.real_x[3*EDW +: EDW])), -63895);
    check("first_im", longint'($signed(bus.imag_y)), -14745);
    wait_done(500);

    // start during the frame_done cycle must be ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    check("start_in_done_ignored", bus.busy, 0);

    // zoom 1 with offset; inputs change mid-frame without effect
    bus.zoom = 3'd1;
    bus.x_offset = 25'h100000;
    bus.y_offset = '0;
    bus.start = 1'b1;
    push_frame(3'd1, 25'h100000, '0);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    bus.zoom = 3'd3;
    bus.x_offset = 25'h0ABCDE;
    bus.y_offset = 25'h1FFFFFF;
    wait_done(500);
    tick();

    // random view, random back-pressure, inputs jittering mid-frame
    rdy_mode = 1;
    jitter = 1'b1;
    for (int f = 0; f < 4; f++) begin
      z  = 3'($urandom);
      xo = EDW'($urandom);
      yo = EDW'($urandom);
      bus.zoom = z;
      bus.x_offset = xo;
      bus.y_offset = yo;
      bus.start = 1'b1;
      push_frame(z, xo, yo);
      tick();
      bus.start = 1'b0;
      wait_done(2000);
      tick();
    end
    jitter = 1'b0;

    // start held high: frames only restart from IDLE
    bus.zoom = 3'd2;
    bus.x_offset = 25'h1F00000;
    bus.y_offset = 25'h0123456;
    bus.start = 1'b1;
    push_frame(3'd2, 25'h1F00000, 25'h0123456);
    for (int f = 0; f < 3; f++) begin
      wait_done(2000);
      tick();
      check("idle_gap_busy", bus.busy, 0);
      if (f < 2) push_frame(3'd2, 25'h1F00000, 25'h0123456);
      else bus.start = 1'b0;
    end
    rdy_mode = 0;
    repeat (4) tick();

    // reset mid-RUN while stalled
    rdy_mode = 2;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    push_frame(3'd0, '0, '0);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("stalled_valid", bus.out_valid, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.frame_done, 0);
    check("mid_rst_real", longint'(bus.real_x == '0), 1);
    check("mid_rst_imag", bus.imag_y, 0);
    check("mid_rst_px", bus.pixel_x_out, 0);
    check("mid_rst_py", bus.pixel_y_out, 0);
    check("mid_rst_last", bus.out_last, 0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    rdy_mode = 0;
    repeat (12) tick();
    check("post_rst_busy", bus.busy, 0);

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/pixel_raster_mapper.md
Name: pixel_raster_mapper

Overview:
- Parametrised successor to the single-pixel coordinate mapper: internally raster-scans a full frame and emits complex-plane coordinates for NUM_LANES horizontally adjacent pixels per beat.
- Uses a valid/ready stream to feed the engine distributor.
- Latches zoom and offsets once per frame, so view changes never tear a frame.
- Sits between the view-control registers and the distributor/engine queue.

Parameters:
- PIXEL_DATA_WIDTH, 10, pixel coordinate width.
- ENGINE_DATA_WIDTH, 25, signed fixed-point coordinate width.
- ENGINE_FRACT_WIDTH, 20, fraction bits of engine coordinates.
- SCREEN_WIDTH, 640, pixels per line; must be a multiple of NUM_LANES.
- SCREEN_HEIGHT, 480, lines per frame.
- NUM_LANES, 1, pixels per output beat (1, 2 or 4).
- BASE_STEP, 4915, complex-plane distance per pixel at zoom 0, in engine format (4915 ≈ 3.0/640).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse; begins a frame when IDLE
- zoom  in  3  step = BASE_STEP >> zoom; sampled at accepted start
- x_offset  in  ENGINE_DATA_WIDTH  signed real centre; sampled at accepted start
- y_offset  in  ENGINE_DATA_WIDTH  signed imaginary centre; sampled at accepted start
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts
- real_x  out  NUM_LANES*ENGINE_DATA_WIDTH  lane k in bits [k*EDW +: EDW]
- imag_y  out  ENGINE_DATA_WIDTH  shared by all lanes
- pixel_x_out  out  PIXEL_DATA_WIDTH  x of lane 0
- pixel_y_out  out  PIXEL_DATA_WIDTH  y of beat
- out_last  out  1  final beat of frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after final beat is accepted

Behaviour:
- Reset (reset==0 at a clk edge) forces the following, regardless of state:
  - state IDLE
  - all outputs 0 and pipeline valids cleared
  - counters cleared
  - shadow registers 0
  - an in-flight frame is discarded; no frame_done.
- States:
  - IDLE: start=1 latches zoom/x_offset/y_offset into shadows, sets x_cnt=0, y_cnt=0, goes to RUN. busy rises the next cycle.
  - RUN: stage 0 issues one beat per advance. x_cnt += NUM_LANES. On wrap, x_cnt=0 and y_cnt+1. After issuing (SCREEN_WIDTH-NUM_LANES, SCREEN_HEIGHT-1), go to DRAIN.
  - DRAIN: no new issue; wait until the last-tagged beat is accepted (out_valid & out_ready & out_last). Then pulse frame_done and go to IDLE.
  - start is ignored outside IDLE. Input changes to zoom or offsets mid-frame have no effect.
- Pipeline, 3 stages, all advancing on adv = out_ready | ~out_valid:
  - S0 counter: x_cnt, y_cnt, last tag.
  - S1 multiply: dx_k = (x_cnt+k) - SCREEN_WIDTH/2 and dy = y_cnt - SCREEN_HEIGHT/2, signed PIXEL_DATA_WIDTH+1. Register prod = d * step.
  - S2 output: real_x lane k = prod_k + x_offset_shadow; imag_y = prod_y + y_offset_shadow.
- Latency: the first beat is out_valid 3 cycles after start is accepted, if out_ready is held high.
- Throughput: one beat per cycle with out_ready=1.
- Stall: with out_valid=1 and out_ready=0, all outputs hold stable and no counter advances. No beat is dropped or duplicated.
- Arithmetic:
  - Product is full width, then arithmetically shifted right by 0 (step is already in engine format).
  - Truncate to ENGINE_DATA_WIDTH LSBs.
  - The add wraps two's-complement; no saturation.
- out_last=1 only on the beat with y=SCREEN_HEIGHT-1 and x=SCREEN_WIDTH-NUM_LANES.
- start in the same cycle as frame_done (state still DRAIN) is ignored.
- frame_done never coincides with out_valid of a new frame.

Decomposition:
- Shared package pixel_map_pkg:
  - state enum (IDLE, RUN, DRAIN)
  - screen-centre constants
  - lane-slice width function
  - default BASE_STEP
- One sub-module, pixel_lane_calc: per-lane registered multiply + offset add. Instantiated NUM_LANES times for real plus once for imaginary.
- Counter, FSM and stall control stay in the top.

Test Plan:
- Reset low mid-RUN with out_ready=0 -> next cycle out_valid=0, busy=0, all outputs 0; no frame_done.
- NUM_LANES=1, zoom=0, offsets 0, out_ready=1, start -> first beat 3 cycles later: pixel (0,0), real_x=-1572800, imag_y=-1179600. Beat at pixel (320,240): real_x=0, imag_y=0.
- zoom=1, x_offset=0x100000 -> first beat real_x=1048576-786240=262336, imag_y=-589680. Change zoom to 3 mid-frame -> values unchanged until the next start.
- NUM_LANES=4 -> first beat lanes real_x = -1572800, -1567885, -1562970, -1558055. 160 beats per line; 76800 beats total; out_last only on the final beat.
- Random out_ready (50%) over a full frame -> scoreboard sees exactly 307200 pixels in raster order, with stable outputs during stalls. frame_done pulses once, the cycle after the last handshake.
- start held high continuously -> a new frame begins only from IDLE. Pulses during RUN/DRAIN are ignored. Frames are back-to-back with no overlap.
